i2c_target: RTL and testbench

- I2C target (responder): the far end of the bus from the existing read/write I2C controllers.
- Watches the synchronized SCL/SDA lines, decodes START, STOP and repeated START, and matches a 7-bit device address.
- ACKs its own address, then exposes an 8-bit register-pointer / data interface to local logic.
- Used on the FPGA side for loopback verification of the controllers, and as a peripheral the door logic can expose to an external MCU.

---
 rtl/i2c_pkg.sv | 16 +
 rtl/i2c_bus_sync.sv | 40 ++++
 rtl/i2c_target.sv | 151 +++++++++++++++
 tb/tb_i2c_target.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and bus constants shared by the I2C target and controllers.
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK
    } i2c_state_t;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    localparam logic RW_READ = 1'b1;
    localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SCL/SDA synchronizer with edge, START and STOP detection.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_q;
    logic [SYNC_STAGES-1:0] sda_q;
    logic scl_s;
    logic scl_d;
    logic sda_d;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= '1;
            sda_q <= '1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_q <= {scl_q[SYNC_STAGES-2:0], scl};
            sda_q <= {sda_q[SYNC_STAGES-2:0], sda};
            scl_d <= scl_s;
            sda_d <= sda_s;
        end
    end
    assign scl_s = scl_q[SYNC_STAGES-1];
    assign sda_s = sda_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    // Qualify with the previous SCL so an SDA+SCL fall in one sample still reads as START.
    assign start_det = scl_d & sda_d & ~sda_s;
    assign stop_det = scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with 7-bit address match and an 8-bit register pointer/data port.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic [3:0] stage
);
    typedef struct packed {
        i2c_state_t state;
        logic [3:0] bit_cnt;
        logic [7:0] shreg;
        logic [7:0] reg_addr;
        logic [7:0] wr_data;
        logic rw, first_byte, ack_ok, load, sda_oe, busy, wr_en, rd_en;
    } regs_t;
    regs_t r;
    regs_t n;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic [7:0] shifted;
    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .reset(reset),
        .scl(i2c_sclk),
        .sda(i2c_sdat),
        .sda_s(sda_s),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start_det(start_det),
        .stop_det(stop_det)
    );
    assign shifted = {r.shreg[6:0], sda_s};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r <= '0;
        else r <= n;
    end
    always_comb begin
        n = r;
        n.wr_en = 1'b0;
        n.rd_en = 1'b0;
        n.load = r.rd_en;
        if (stop_det) begin
            n.state = IDLE;
            n.sda_oe = 1'b0;
            n.busy = 1'b0;
        end else if (start_det) begin
            n.state = ADDR;
            n.sda_oe = 1'b0;
            n.bit_cnt = 4'd0;
        end else begin
            case (r.state)
                ADDR: begin
                    if (scl_rise) begin
                        n.shreg = shifted;
                        n.bit_cnt = r.bit_cnt + 4'd1;
                    end else if (scl_fall && r.bit_cnt == 4'd8) begin
                        n.sda_oe = r.shreg[7:1] == DEV_ADDR;
                        n.busy = r.shreg[7:1] == DEV_ADDR;
                        n.state = r.shreg[7:1] == DEV_ADDR ? ADDR_ACK : IDLE;
                        n.rw = r.shreg[0];
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        n.sda_oe = 1'b0;
                        n.bit_cnt = 4'd0;
                        n.first_byte = 1'b1;
                        n.rd_en = r.rw == RW_READ;
                        n.state = r.rw == RW_READ ? RD_BYTE : WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        n.shreg = shifted;
                        n.bit_cnt = r.bit_cnt + 4'd1;
                        if (r.bit_cnt == 4'd7) begin
                            n.reg_addr = r.first_byte ? shifted : r.reg_addr;
                            n.wr_data = r.first_byte ? r.wr_data : shifted;
                            n.wr_en = ~r.first_byte;
                        end
                    end else if (scl_fall && r.bit_cnt == 4'd8) begin
                        n.sda_oe = 1'b1;
                        n.state = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        n.sda_oe = 1'b0;
                        n.first_byte = 1'b0;
                        n.bit_cnt = 4'd0;
                        n.reg_addr = r.first_byte ? r.reg_addr : r.reg_addr + 8'd1;
                        n.state = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    // rd_data arrives two clks after the fall that requested it
                    if (r.load) begin
                        n.shreg = rd_data;
                        n.sda_oe = ~rd_data[7];
                        n.bit_cnt = 4'd0;
                    end else if (scl_fall) begin
                        n.shreg = {r.shreg[6:0], 1'b0};
                        n.sda_oe = r.bit_cnt == 4'd7 ? 1'b0 : ~r.shreg[6];
                        n.bit_cnt = r.bit_cnt + 4'd1;
                        n.ack_ok = 1'b0;
                        n.state = r.bit_cnt == 4'd7 ? RD_ACK : RD_BYTE;
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == NACK) begin
                            n.state = IDLE;
                            n.busy = 1'b0;
                            n.sda_oe = 1'b0;
                        end else begin
                            n.reg_addr = r.reg_addr + 8'd1;
                            n.ack_ok = 1'b1;
                        end
                    end else if (scl_fall && r.ack_ok) begin
                        n.ack_ok = 1'b0;
                        n.rd_en = 1'b1;
                        n.state = RD_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end
    assign i2c_sdat = r.sda_oe ? 1'b0 : 1'bz;
    assign reg_addr = r.reg_addr;
    assign wr_data = r.wr_data;
    assign wr_en = r.wr_en;
    assign rd_en = r.rd_en;
    assign busy = r.busy;
    assign stage = r.state;
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller driving i2c_target, with wr_en/rd_en scoreboards.
module tb_i2c_target;
    import i2c_pkg::*;
    localparam int Q = 80;
    logic clk;
    logic reset;
    logic scl;
    logic tb_sda_low;
    wire i2c_sdat;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic wr_en;
    logic rd_en;
    logic [7:0] rd_data;
    logic busy;
    logic [3:0] stage;
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    i2c_target dut (
        .clk(clk),
        .reset(reset),
        .i2c_sclk(scl),
        .i2c_sdat(i2c_sdat),
        .reg_addr(reg_addr),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .busy(busy),
        .stage(stage)
    );
    assign i2c_sdat = tb_sda_low ? 1'b0 : 1'bz;
    pullup (i2c_sdat);
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial rd_data = 8'h00;
    always @(posedge clk) if (rd_en) rd_data <= reg_addr ^ 8'h5A;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_expected", 32'(exp_wr.size()), exp_wr.size() == 0 ? 32'd1 : 32'(exp_wr.size()));
            if (exp_wr.size() != 0) check("wr_pair", 32'({reg_addr, wr_data}), 32'(exp_wr.pop_front()));
        end
        if (rd_en) begin
            check("rd_expected", 32'(exp_rd.size()), exp_rd.size() == 0 ? 32'd1 : 32'(exp_rd.size()));
            if (exp_rd.size() != 0) check("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
        end
    end
    task automatic clock_bit(input logic d, output logic s);
        tb_sda_low = ~d;
        #Q;
        scl = 1'b1;
        #Q;
        s = i2c_sdat;
        #Q;
        scl = 1'b0;
        #Q;
    endtask
    task automatic bus_start;
        tb_sda_low = 1'b0;
        #Q;
        scl = 1'b1;
        #Q;
        tb_sda_low = 1'b1;
        #Q;
        scl = 1'b0;
        #Q;
    endtask
    task automatic bus_stop;
        tb_sda_low = 1'b1;
        #Q;
        scl = 1'b1;
        #Q;
        tb_sda_low = 1'b0;
        #Q;
    endtask
    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, ack);
    endtask
    task automatic read_byte(input logic ack_drive, output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            b = {b[6:0], s};
        end
        clock_bit(ack_drive, s);
    endtask
    initial begin
        logic ack;
        logic [7:0] b;
        logic s;
        reset = 1'b1;
        scl = 1'b1;
        tb_sda_low = 1'b0;
        #20;
        check("rst_sda", 32'(i2c_sdat), 1);
        check("rst_outs", 32'({reg_addr, wr_data, wr_en, rd_en, busy}), 0);
        check("rst_stage", 32'(stage), 32'(IDLE));
        #20;
        reset = 1'b0;
        #(2 * Q);
        // plain write: pointer 0x10 then two data bytes
        bus_start();
        write_byte(8'h84, ack);
        check("t1_addr_ack", 32'(ack), 32'(ACK));
        check("t1_busy", 32'(busy), 1);
        write_byte(8'h10, ack);
        check("t1_ptr_ack", 32'(ack), 32'(ACK));
        exp_wr.push_back({8'h10, 8'hA5});
        write_byte(8'hA5, ack);
        check("t1_d0_ack", 32'(ack), 32'(ACK));
        exp_wr.push_back({8'h11, 8'h3C});
        write_byte(8'h3C, ack);
        check("t1_d1_ack", 32'(ack), 32'(ACK));
        bus_stop();
        #Q;
        check("t1_reg_addr", 32'(reg_addr), 32'h12);
        check("t1_busy_end", 32'(busy), 0);
        check("t1_wr_drained", 32'(exp_wr.size()), 0);
        // pointer write 0xFF, repeated START, two-byte read across the wrap
        bus_start();
        write_byte(8'h84, ack);
        check("t2_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'hFF, ack);
        check("t2_ptr_ack", 32'(ack), 32'(ACK));
        bus_start();
        check("t2_ptr_kept", 32'(reg_addr), 32'hFF);
        exp_rd.push_back(8'hFF);
        exp_rd.push_back(8'h00);
        write_byte(8'h85, ack);
        check("t2_raddr_ack", 32'(ack), 32'(ACK));
        read_byte(ACK, b);
        check("t2_rd0", 32'(b), 32'hA5);
        check("t2_busy_mid", 32'(busy), 1);
        read_byte(NACK, b);
        check("t2_rd1", 32'(b), 32'h5A);
        check("t2_busy_nack", 32'(busy), 0);
        check("t2_stage", 32'(stage), 32'(IDLE));
        check("t2_reg_addr", 32'(reg_addr), 32'h00);
        bus_stop();
        #Q;
        check("t2_rd_drained", 32'(exp_rd.size()), 0);
        // address mismatch: no ACK driven
        bus_start();
        write_byte(8'h86, ack);
        check("t3_nack", 32'(ack), 32'(NACK));
        check("t3_busy", 32'(busy), 0);
        check("t3_stage", 32'(stage), 32'(IDLE));
        bus_stop();
        #Q;
        // STOP in the middle of a data byte
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h20, ack);
        check("t4_ptr_ack", 32'(ack), 32'(ACK));
        for (int i = 0; i < 4; i++) clock_bit(i[0], s);
        bus_stop();
        #Q;
        check("t4_reg_addr", 32'(reg_addr), 32'h20);
        check("t4_stage", 32'(stage), 32'(IDLE));
        check("t4_sda", 32'(i2c_sdat), 1);
        check("t4_busy", 32'(busy), 0);
        // reset while the target drives a 0 read bit
        bus_start();
        write_byte(8'h84, ack);
        write_byte(8'h30, ack);
        bus_start();
        exp_rd.push_back(8'h30);
        write_byte(8'h85, ack);
        check("t5_raddr_ack", 32'(ack), 32'(ACK));
        check("t5_drive0", 32'(i2c_sdat), 0);
        check("t5_stage_rd", 32'(stage), 32'(RD_BYTE));
        reset = 1'b1;
        #1;
        check("t5_sda_rel", 32'(i2c_sdat), 1);
        check("t5_outs", 32'({reg_addr, wr_data, wr_en, rd_en, busy}), 0);
        check("t5_stage", 32'(stage), 32'(IDLE));
        #9;
        scl = 1'b1;
        #40;
        reset = 1'b0;
        #(2 * Q);
        check("t5_rd_drained", 32'(exp_rd.size()), 0);
        bus_start();
        write_byte(8'h84, ack);
        check("t5_re_ack", 32'(ack), 32'(ACK));
        write_byte(8'h01, ack);
        bus_stop();
        #Q;
        check("t5_reg_addr", 32'(reg_addr), 32'h01);
        // SDA and SCL fall in the same sample: must be a START
        tb_sda_low = 1'b1;
        scl = 1'b0;
        #30;
        check("t6_stage", 32'(stage), 32'(ADDR));
        write_byte(8'h84, ack);
        check("t6_addr_ack", 32'(ack), 32'(ACK));
        write_byte(8'h55, ack);
        bus_stop();
        #Q;
        check("t6_reg_addr", 32'(reg_addr), 32'h55);
        #(4 * Q);
        check("end_wr_q", 32'(exp_wr.size()), 0);
        check("end_rd_q", 32'(exp_rd.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
